register_bank: RTL

- 32-entry × 32-bit general-purpose register file for the single-cycle RISC datapath.
- Sits directly downstream of the 5-bit write-address multiplexor, which selects rd, rt or the link register (31). That mux output drives wr_addr here.
- Two combinational read ports feed the ALU operand path. One synchronous write port takes the writeback result.
- A third read port (debug) lets the testbench and the top-level display logic inspect any register.

---
 rtl/register_bank.sv | 82 ++++++++
 1 files changed

// File: rtl/register_bank.sv
// 32-entry general-purpose register file: two combinational read ports with
// optional write-through bypass, one synchronous write port, a debug read port
// and a saturating count of committed writes.
module register_bank #(
    parameter int               WIDTH    = 32,
    parameter int               BYPASS   = 1,
    parameter int               SP_INDEX = 29,
    parameter logic [WIDTH-1:0] SP_INIT  = 'h0000_0FFC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rd_addr0,
    input  logic [4:0]       rd_addr1,
    output logic [WIDTH-1:0] rd_data0,
    output logic [WIDTH-1:0] rd_data1,
    input  logic             wr_en,
    input  logic [4:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [4:0]       dbg_addr,
    output logic [WIDTH-1:0] dbg_data,
    output logic [15:0]      wr_count
);

    logic [WIDTH-1:0] regs_reg [32];
    logic [15:0]      count_reg;
    logic             commit;

    // A write only takes effect when reset is idle and the target is not r0.
    assign commit = !rst && wr_en && (wr_addr != 5'd0);

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                always_ff @(posedge clk) begin
                    regs_reg[gi] <= '0;
                end
            end else begin : g_gpr
                always_ff @(posedge clk) begin
                    if (rst) begin
                        regs_reg[gi] <= (gi == SP_INDEX) ? SP_INIT : '0;
                    end else if (wr_en && (wr_addr == 5'(gi))) begin
                        regs_reg[gi] <= wr_data;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (commit && (count_reg != 16'hFFFF)) begin
            count_reg <= count_reg + 16'd1;
        end
    end

    always_comb begin
        rd_data0 = '0;
        rd_data1 = '0;
        dbg_data = '0;
        if (rd_addr0 != 5'd0) begin
            rd_data0 = regs_reg[rd_addr0];
            if ((BYPASS != 0) && commit && (wr_addr == rd_addr0)) begin
                rd_data0 = wr_data;
            end
        end
        if (rd_addr1 != 5'd0) begin
            rd_data1 = regs_reg[rd_addr1];
            if ((BYPASS != 0) && commit && (wr_addr == rd_addr1)) begin
                rd_data1 = wr_data;
            end
        end
        // Debug port always shows committed state, never the in-flight write.
        if (dbg_addr != 5'd0) begin
            dbg_data = regs_reg[dbg_addr];
        end
    end

    assign wr_count = count_reg;

endmodule
